// File: rtl/rtc_mux_bus_master_if.sv
// Command-side bundle of the RTC multiplexed-bus master.
// master: control FSM side; slave: the bus master block.
interface rtc_mux_bus_master_if #(
   parameter int DATA_W = 8,
   parameter int LEN_W  = 5
);
   logic              start;
   logic              cmd_wr;
   logic [DATA_W-1:0] addr;
   logic [LEN_W-1:0]  len;
   logic [DATA_W-1:0] wdata;
   logic              abort;
   logic              busy;
   logic              wr_taken;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic              done;
   logic              aborted;

   modport master (
      output start, cmd_wr, addr, len, wdata, abort,
      input  busy, wr_taken, rd_valid, rd_data, done, aborted
   );

   modport slave (
      input  start, cmd_wr, addr, len, wdata, abort,
      output busy, wr_taken, rd_valid, rd_data, done, aborted
   );
endinterface

// File: rtl/rtc_mux_bus_master.sv
// Burst master for the RTC multiplexed address/data bus.
// Ports: CLK, RST (sync, high); cmd (command bundle, slave side);
// CS/RD/WR/AD active-low strobes; A_D_Bus shared address/data bus.
module rtc_mux_bus_master #(
   parameter int DATA_W    = 8,
   parameter int T_SU      = 1,
   parameter int T_PW      = 3,
   parameter int T_HD      = 1,
   parameter int T_GAP     = 2,
   parameter int BURST_MAX = 16,
   localparam int LEN_W    = $clog2(BURST_MAX + 1)
) (
   input  logic                     CLK,
   input  logic                     RST,
   rtc_mux_bus_master_if.slave      cmd,
   output logic                     CS,
   output logic                     RD,
   output logic                     WR,
   output logic                     AD,
   inout  wire  [DATA_W-1:0]        A_D_Bus
);
   localparam int M1 = (T_SU > T_PW) ? T_SU : T_PW;
   localparam int M2 = (T_HD > T_GAP) ? T_HD : T_GAP;
   localparam int CW = $clog2(((M1 > M2) ? M1 : M2) + 1);

   typedef enum logic [2:0] {
      IDLE, ADDR_SU, ADDR_PW, ADDR_HD,
      DATA_SU, DATA_PW, DATA_HD, GAP
   } state_t;

   state_t            state, state_n;
   logic [CW-1:0]     cnt, cnt_n, dur;
   logic [DATA_W-1:0] addr_q, addr_n;
   logic [LEN_W-1:0]  left_q, left_n, len_eff;
   logic              wr_q, wr_n;
   logic              done_n, abrt_n, rdv_n;
   logic              a_ph, d_ph, ent_dsu;
   logic              oe;
   logic [DATA_W-1:0] dout;

   assign A_D_Bus = oe ? dout : {DATA_W{1'bz}};

   always_comb begin
      len_eff = cmd.len;
      if (cmd.len == '0)
         len_eff = LEN_W'(1);
      else if (cmd.len > LEN_W'(BURST_MAX))
         len_eff = LEN_W'(BURST_MAX);
   end

   always_comb begin
      unique case (state)
         ADDR_SU, DATA_SU: dur = CW'(T_SU - 1);
         ADDR_PW, DATA_PW: dur = CW'(T_PW - 1);
         ADDR_HD, DATA_HD: dur = CW'(T_HD - 1);
         GAP:              dur = CW'(T_GAP - 1);
         default:          dur = '0;
      endcase
   end

   // Next state; outputs are registered from state_n so that the
   // pins change on the same edge that enters a phase.
   always_comb begin
      state_n = state;
      cnt_n   = cnt + 1'b1;
      addr_n  = addr_q;
      left_n  = left_q;
      wr_n    = wr_q;
      done_n  = 1'b0;
      abrt_n  = 1'b0;
      rdv_n   = 1'b0;
      if (state == IDLE) begin
         cnt_n = '0;
         if (cmd.start && !cmd.abort) begin
            state_n = ADDR_SU;
            addr_n  = cmd.addr;
            wr_n    = cmd.cmd_wr;
            left_n  = len_eff;
         end
      end else if (cmd.abort) begin
         state_n = IDLE;
         cnt_n   = '0;
         done_n  = 1'b1;
         abrt_n  = 1'b1;
      end else if (cnt == dur) begin
         cnt_n = '0;
         unique case (state)
            ADDR_SU: state_n = ADDR_PW;
            ADDR_PW: state_n = ADDR_HD;
            ADDR_HD: state_n = DATA_SU;
            DATA_SU: state_n = DATA_PW;
            DATA_PW: begin
               state_n = DATA_HD;
               rdv_n   = !wr_q;
            end
            DATA_HD: state_n = GAP;
            GAP: begin
               if (left_q > LEN_W'(1)) begin
                  state_n = ADDR_SU;
                  addr_n  = addr_q + 1'b1;
                  left_n  = left_q - 1'b1;
               end else begin
                  state_n = IDLE;
                  done_n  = 1'b1;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_comb begin
      a_ph    = (state_n == ADDR_SU) || (state_n == ADDR_PW) ||
                (state_n == ADDR_HD);
      d_ph    = (state_n == DATA_SU) || (state_n == DATA_PW) ||
                (state_n == DATA_HD);
      ent_dsu = (state_n == DATA_SU) && (state != DATA_SU);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state        <= IDLE;
         cnt          <= '0;
         addr_q       <= '0;
         left_q       <= '0;
         wr_q         <= 1'b0;
         CS           <= 1'b1;
         RD           <= 1'b1;
         WR           <= 1'b1;
         AD           <= 1'b1;
         oe           <= 1'b0;
         dout         <= '0;
         cmd.busy     <= 1'b0;
         cmd.wr_taken <= 1'b0;
         cmd.rd_valid <= 1'b0;
         cmd.rd_data  <= '0;
         cmd.done     <= 1'b0;
         cmd.aborted  <= 1'b0;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         addr_q       <= addr_n;
         left_q       <= left_n;
         wr_q         <= wr_n;
         cmd.busy     <= (state_n != IDLE);
         CS           <= (state_n == IDLE) || (state_n == GAP);
         AD           <= !a_ph;
         // The address latch is clocked by WR for reads too.
         WR           <= !((state_n == ADDR_PW) ||
                           ((state_n == DATA_PW) && wr_n));
         RD           <= !((state_n == DATA_PW) && !wr_n);
         oe           <= a_ph || (d_ph && wr_n);
         cmd.wr_taken <= ent_dsu && wr_n;
         if (a_ph)
            dout <= addr_n;
         else if (ent_dsu && wr_n)
            dout <= cmd.wdata;
         cmd.rd_valid <= rdv_n;
         if (rdv_n)
            cmd.rd_data <= A_D_Bus;
         cmd.done     <= done_n;
         cmd.aborted  <= abrt_n;
      end
   end
endmodule

// File: tb/tb_rtc_mux_bus_master.sv
// Scoreboard bench for rtc_mux_bus_master with a small RTC model.
// Stimulus pushes expected beats; a negedge monitor pops and compares.
module tb_rtc_mux_bus_master;
   localparam int T_PW = 3;
   localparam int T_GAP = 2;
   localparam int BEAT = 12;
   localparam int CS_LOW = 10;

   typedef struct {
      bit ab;
      int lat;
      int n_wr;
      int n_rd;
      int n_wt;
   } done_t;

   logic clk = 1'b0;
   logic rst;
   logic CS, RD, WR, AD;
   wire  [7:0] ad_bus;
   logic [7:0] rtc_addr = 8'h00;

   int checks = 0;
   int errors = 0;

   logic [7:0] aq[$];
   logic [7:0] rq[$];
   logic [7:0] wq[$];
   logic [7:0] wd_q[$];
   done_t      dq[$];

   rtc_mux_bus_master_if #(.DATA_W(8), .LEN_W(5)) cmd ();

   rtc_mux_bus_master dut (
      .CLK     (clk),
      .RST     (rst),
      .cmd     (cmd),
      .CS      (CS),
      .RD      (RD),
      .WR      (WR),
      .AD      (AD),
      .A_D_Bus (ad_bus)
   );

   // RTC model: returns latched address XOR 0xFF while RD is low.
   assign ad_bus = (RD == 1'b0) ? (rtc_addr ^ 8'hFF) : 8'hzz;

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic miss(input string name, input logic [31:0] act);
      checks++;
      errors++;
      $display("FAIL %s: got %0h expected nothing", name, act);
   endtask

   // Monitor state
   int   pw_wr, pw_rd, cs_lo, gap, busy_cyc;
   int   n_wr, n_rd, n_wt;
   logic p_wr, p_rd, p_cs;
   logic w_ad;
   logic [7:0] w_bus;
   bit   ab_now;
   done_t d;

   always @(negedge clk) begin
      if (rst) begin
         pw_wr = 0; pw_rd = 0; cs_lo = 0; gap = 0; busy_cyc = 0;
         n_wr = 0; n_rd = 0; n_wt = 0;
         p_wr = 1'b1; p_rd = 1'b1; p_cs = 1'b1;
      end else begin
         ab_now = cmd.done && cmd.aborted;
         if (!WR) begin
            if (p_wr) begin
               w_ad  = AD;
               w_bus = ad_bus;
               n_wr++;
               if (!AD) rtc_addr = ad_bus;
            end
            pw_wr++;
         end else if (!p_wr) begin
            if (!ab_now) check("wr_width", pw_wr, T_PW);
            if (!w_ad) begin
               if (aq.size() == 0) miss("addr_extra", w_bus);
               else check("addr", w_bus, aq.pop_front());
            end else begin
               if (wq.size() == 0) miss("wdata_extra", w_bus);
               else check("wdata_bus", w_bus, wq.pop_front());
            end
            pw_wr = 0;
         end
         if (!RD) begin
            if (p_rd) n_rd++;
            pw_rd++;
         end else if (!p_rd) begin
            if (!ab_now) check("rd_width", pw_rd, T_PW);
            pw_rd = 0;
         end
         if (!CS) begin
            if (p_cs && gap > 0) check("cs_gap", gap, T_GAP);
            if (p_cs) gap = 0;
            cs_lo++;
         end else begin
            if (!p_cs) begin
               if (!ab_now) check("cs_low", cs_lo, CS_LOW);
               cs_lo = 0;
            end
            if (cmd.busy) gap++;
            else gap = 0;
         end
         if (cmd.busy) busy_cyc++;
         if (cmd.wr_taken) begin
            n_wt++;
            if (wd_q.size() == 0) miss("wr_taken_extra", 1);
            else void'(wd_q.pop_front());
         end
         if (cmd.rd_valid) begin
            if (rq.size() == 0) miss("rd_valid_extra", cmd.rd_data);
            else check("rd_data", cmd.rd_data, rq.pop_front());
         end
         if (cmd.done) begin
            if (dq.size() == 0) begin
               miss("done_extra", 1);
            end else begin
               d = dq.pop_front();
               check("aborted", cmd.aborted, d.ab);
               check("busy_at_done", cmd.busy, 0);
               check("pins_at_done", {CS, RD, WR, AD}, 4'hF);
               if (d.lat >= 0) check("latency", busy_cyc, d.lat);
               check("wr_pulses", n_wr, d.n_wr);
               check("rd_pulses", n_rd, d.n_rd);
               check("wr_taken_cnt", n_wt, d.n_wt);
            end
            busy_cyc = 0; n_wr = 0; n_rd = 0; n_wt = 0;
         end
         p_wr = WR; p_rd = RD; p_cs = CS;
      end
      cmd.wdata = (wd_q.size() != 0) ? wd_q[0] : 8'h00;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: one beat per address, address wraps at 8 bits.
   task automatic issue(input bit wr, input logic [7:0] a, input int l);
      int n;
      logic [7:0] ba, dv;
      n = (l == 0) ? 1 : ((l > 16) ? 16 : l);
      for (int i = 0; i < n; i++) begin
         ba = 8'((int'(a) + i) % 256);
         aq.push_back(ba);
         if (wr) begin
            dv = 8'($urandom_range(0, 255));
            wd_q.push_back(dv);
            wq.push_back(dv);
         end else begin
            rq.push_back(ba ^ 8'hFF);
         end
      end
      dq.push_back('{0, BEAT * n, wr ? 2 * n : n, wr ? 0 : n,
                     wr ? n : 0});
      cmd.start  = 1'b1;
      cmd.cmd_wr = wr;
      cmd.addr   = a;
      cmd.len    = 5'(l);
      tick();
      cmd.start  = 1'b0;
      cmd.cmd_wr = 1'($urandom_range(0, 1));
      cmd.addr   = 8'($urandom_range(0, 255));
      cmd.len    = 5'($urandom_range(0, 31));
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((dq.size() != 0 || cmd.busy) && n < 400) begin
         tick();
         n++;
      end
      if (n >= 400) begin
         miss("timeout_busy", cmd.busy);
         dq.delete();
      end
      tick();
   endtask

   initial begin
      rst        = 1'b1;
      cmd.start  = 1'b0;
      cmd.cmd_wr = 1'b0;
      cmd.addr   = 8'h00;
      cmd.len    = 5'd0;
      cmd.abort  = 1'b0;
      repeat (3) tick();
      check("rst_pins", {CS, RD, WR, AD}, 4'hF);
      check("rst_busy", cmd.busy, 0);
      check("rst_pulses", {cmd.wr_taken, cmd.rd_valid, cmd.done,
                           cmd.aborted}, 4'h0);
      check("rst_rd_data", cmd.rd_data, 8'h00);
      rst = 1'b0;
      tick();

      // Single write, then the read burst and the length corners.
      issue(1'b1, 8'h21, 1);
      check("start_pins", {cmd.busy, CS, AD}, 3'b100);
      wait_idle();
      issue(1'b0, 8'h21, 3);
      wait_idle();
      issue(1'b0, 8'hFF, 2);
      wait_idle();
      issue(1'b1, 8'h10, 0);
      wait_idle();
      issue(1'b0, 8'hF8, 31);
      wait_idle();

      // Abort on the last DATA_PW cycle of beat two.
      aq.push_back(8'h30);
      aq.push_back(8'h31);
      rq.push_back(8'h30 ^ 8'hFF);
      dq.push_back('{1, -1, 2, 2, 0});
      cmd.start  = 1'b1;
      cmd.cmd_wr = 1'b0;
      cmd.addr   = 8'h30;
      cmd.len    = 5'd4;
      tick();
      cmd.start = 1'b0;
      repeat (20) tick();
      check("abort_in_rd_pw", RD, 0);
      cmd.abort = 1'b1;
      tick();
      cmd.abort = 1'b0;
      check("abort_pins", {CS, RD, WR, AD}, 4'hF);
      check("abort_flags", {cmd.done, cmd.aborted, cmd.busy,
                            cmd.rd_valid}, 4'b1100);
      wait_idle();

      // Abort together with start while idle: nothing starts.
      cmd.start = 1'b1;
      cmd.abort = 1'b1;
      cmd.addr  = 8'h77;
      tick();
      cmd.start = 1'b0;
      cmd.abort = 1'b0;
      check("abort_start_busy", {cmd.busy, CS}, 2'b01);
      repeat (3) tick();

      // Second start mid-burst is ignored.
      issue(1'b0, 8'h40, 3);
      repeat (5) tick();
      cmd.start  = 1'b1;
      cmd.cmd_wr = 1'b1;
      cmd.addr   = 8'h90;
      cmd.len    = 5'd1;
      tick();
      cmd.start = 1'b0;
      wait_idle();

      // Reset during ADDR_PW of a write: no done, clean restart.
      issue(1'b1, 8'h55, 2);
      repeat (2) tick();
      check("rst_in_addr_pw", {WR, AD}, 2'b00);
      rst = 1'b1;
      tick();
      check("midrst_pins", {CS, RD, WR, AD}, 4'hF);
      check("midrst_flags", {cmd.busy, cmd.done}, 2'b00);
      rst = 1'b0;
      aq.delete(); rq.delete(); wq.delete(); wd_q.delete(); dq.delete();
      repeat (20) tick();
      issue(1'b1, 8'h66, 2);
      wait_idle();

      // Random commands.
      repeat (12) begin
         issue(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
               int'($urandom_range(0, 20)));
         wait_idle();
         repeat ($urandom_range(0, 3)) tick();
      end

      check("leftover", aq.size() + rq.size() + wq.size() + dq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
